// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the RISC-V M extension.
// Uses radix-2 shift-add multiplication and restoring division, one bit per cycle,
// so every operation has the same latency. Special cases are decided when the
// request is accepted and substituted at completion.
module mul_div_unit #(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            busy_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_VAL = {XLEN{1'b0}};

  // Two's-complement negation at operand/result width.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a full double-width product.
  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_r, state_next_s;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        op_r;
  logic [4:0]        rd_r;
  logic [XLEN-1:0]   a_r;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi_r;     // product high half or partial remainder
  logic [XLEN-1:0]   lo_r;     // multiplier/product low half or dividend/quotient
  logic              neg_r;    // negate product/quotient
  logic              rneg_r;   // negate remainder
  logic              special_r;
  logic [XLEN-1:0]   special_val_r;

  logic              accept_s, finish_s;
  logic              s1_s, s2_s, is_div_s, div0_s, ovf_s;
  logic [XLEN-1:0]   mag1_s, mag2_s;
  logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic              qbit_s;
  logic [XLEN-1:0]   step_hi_s, step_lo_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, result_s;

  assign ready_o = (state_r == IDLE);
  assign busy_o  = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic plus accept/finish strobes; flush wins over a new request.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_i && !flush_i) begin
          accept_s     = 1'b1;
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_next_s = IDLE;
        end else if (cnt_r == LAST_CNT) begin
          finish_s     = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand signs, magnitudes and special-case detection at accept time.
  always_comb begin
    is_div_s = op_i[2];
    s1_s     = rs1_data_i[XLEN-1] && ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                                      (op_i == OP_DIV)  || (op_i == OP_REM));
    s2_s     = rs2_data_i[XLEN-1] && ((op_i == OP_MULH) || (op_i == OP_DIV) ||
                                      (op_i == OP_REM));
    mag1_s   = s1_s ? neg_x(rs1_data_i) : rs1_data_i;
    mag2_s   = s2_s ? neg_x(rs2_data_i) : rs2_data_i;
    div0_s   = is_div_s && (rs2_data_i == ZERO_VAL);
    ovf_s    = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
               (rs1_data_i == MIN_VAL) && (rs2_data_i == ONES_VAL);
  end

  // One iteration of shift-add or restoring divide, plus final sign fix-up.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(XLEN+1){1'b0}});
    div_shift_s = {hi_r, lo_r[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, a_r};
    qbit_s      = ~div_diff_s[XLEN];
    if (op_r[2]) begin
      step_hi_s = qbit_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
      step_lo_s = {lo_r[XLEN-2:0], qbit_s};
    end else begin
      step_hi_s = mul_sum_s[XLEN:1];
      step_lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
    prod_s = neg_r ? neg_2x({step_hi_s, step_lo_s}) : {step_hi_s, step_lo_s};
    quo_s  = neg_r ? neg_x(step_lo_s) : step_lo_s;
    rem_s  = rneg_r ? neg_x(step_hi_s) : step_hi_s;
    if (special_r) begin
      result_s = special_val_r;
    end else if (op_r[2]) begin
      result_s = op_r[1] ? rem_s : quo_s;
    end else if (op_r[1:0] == 2'b00) begin
      result_s = prod_s[XLEN-1:0];
    end else begin
      result_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Datapath registers and registered result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r         <= {CW{1'b0}};
      op_r          <= 3'b000;
      rd_r          <= 5'd0;
      a_r           <= ZERO_VAL;
      hi_r          <= ZERO_VAL;
      lo_r          <= ZERO_VAL;
      neg_r         <= 1'b0;
      rneg_r        <= 1'b0;
      special_r     <= 1'b0;
      special_val_r <= ZERO_VAL;
      valid_o       <= 1'b0;
      result_o      <= ZERO_VAL;
      rd_o          <= 5'd0;
    end else begin
      valid_o <= finish_s;
      if (finish_s) begin
        result_o <= result_s;
        rd_o     <= rd_r;
      end
      if (accept_s) begin
        cnt_r     <= {CW{1'b0}};
        op_r      <= op_i;
        rd_r      <= rd_i;
        a_r       <= is_div_s ? mag2_s : mag1_s;
        lo_r      <= is_div_s ? mag1_s : mag2_s;
        hi_r      <= ZERO_VAL;
        neg_r     <= s1_s ^ s2_s;
        rneg_r    <= s1_s;
        special_r <= div0_s || ovf_s;
        if (div0_s) begin
          special_val_r <= op_i[1] ? rs1_data_i : ONES_VAL;
        end else begin
          special_val_r <= op_i[1] ? ZERO_VAL : MIN_VAL;
        end
      end else if (state_r == CALC) begin
        cnt_r <= cnt_r + CW'(1);
        hi_r  <= step_hi_s;
        lo_r  <= step_lo_s;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: a 32-bit instance for the main
// operations, special cases and flush, and an 8-bit instance for reset mid-CALC.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        rst, flush, valid, ready, busy, vo;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, res;
  logic [4:0]  rd, rdo;

  // 8-bit instance signals
  logic        rst8, flush8, valid8, ready8, busy8, vo8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic [4:0]  rd8, rdo8;

  int checks = 0;
  int failures = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid),
    .ready_o(ready), .busy_o(busy), .op_i(op), .rs1_data_i(rs1),
    .rs2_data_i(rs2), .rd_i(rd), .valid_o(vo), .result_o(res), .rd_o(rdo)
  );

  mul_div_unit #(.XLEN(8)) dut8 (
    .clk_i(clk), .rst_i(rst8), .flush_i(flush8), .valid_i(valid8),
    .ready_o(ready8), .busy_o(busy8), .op_i(op8), .rs1_data_i(a8),
    .rs2_data_i(b8), .rd_i(rd8), .valid_o(vo8), .result_o(res8), .rd_o(rdo8)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the selected instance, then watch strobe timing, result, tag and ready.
  task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t,
                        input logic [31:0] exp, input string tag);
    int lat, strobe_cyc, strobes, ready_bad;
    logic [31:0] got;
    logic [4:0]  got_rd;
    lat = w8 ? 9 : 33;
    strobe_cyc = 0; strobes = 0; ready_bad = 0; got = 32'd0; got_rd = 5'd0;
    @(negedge clk);
    if (w8) begin
      valid8 = 1'b1; op8 = o; a8 = a[7:0]; b8 = b[7:0]; rd8 = t;
    end else begin
      valid = 1'b1; op = o; rs1 = a; rs2 = b; rd = t;
    end
    for (int c = 1; c <= lat + 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        valid = 1'b0; valid8 = 1'b0;
        rs1 = 32'hA5A5_5A5A; rs2 = 32'h1234_5678; a8 = 8'h3C; b8 = 8'hC3;
      end
      if (w8) begin
        if (vo8) begin
          strobes++;
          if (strobe_cyc == 0) begin strobe_cyc = c; got = {24'd0, res8}; got_rd = rdo8; end
        end
        if ((c <= lat && ready8) || (c == lat + 1 && !ready8)) ready_bad++;
      end else begin
        if (vo) begin
          strobes++;
          if (strobe_cyc == 0) begin strobe_cyc = c; got = res; got_rd = rdo; end
        end
        if ((c <= lat && ready) || (c == lat + 1 && !ready)) ready_bad++;
      end
    end
    check_eq({tag, "_lat"}, 64'(strobe_cyc), 64'(lat));
    check_eq({tag, "_nstrobe"}, 64'(strobes), 64'd1);
    check_eq({tag, "_result"}, {32'd0, got}, {32'd0, exp});
    check_eq({tag, "_rd"}, {59'd0, got_rd}, {59'd0, t});
    check_eq({tag, "_ready"}, 64'(ready_bad), 64'd0);
  endtask

  initial begin
    int strobes;
    rst = 1'b1; flush = 1'b0; valid = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0; rd = 5'd0;
    rst8 = 1'b1; flush8 = 1'b0; valid8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0; rd8 = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {63'd0, ready}, 64'd1);
    check_eq("rst_busy",  {63'd0, busy},  64'd0);
    check_eq("rst_valid", {63'd0, vo},    64'd0);
    check_eq("rst_result", {32'd0, res},  64'd0);
    check_eq("rst_rd", {59'd0, rdo}, 64'd0);

    run_op(1'b0, 3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, "mul");
    run_op(1'b0, 3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, "mulh");
    run_op(1'b0, 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, "mulhu");
    run_op(1'b0, 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, "mulhsu");
    run_op(1'b0, 3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, "div");
    run_op(1'b0, 3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, "rem");
    run_op(1'b0, 3'b101, 32'd7,          32'd2,         5'd11, 32'd3,         "divu");
    run_op(1'b0, 3'b111, 32'hFFFF_FFFF,  32'd16,        5'd12, 32'd15,        "remu");
    run_op(1'b0, 3'b100, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, "div0");
    run_op(1'b0, 3'b111, 32'd5,          32'd0,         5'd14, 32'd5,         "remu0");
    run_op(1'b0, 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, "divovf");
    run_op(1'b0, 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         "removf");

    // Flush a DIV in cycle 10; a busy-time request must be ignored.
    strobes = 0;
    @(negedge clk);
    valid = 1'b1; op = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd20;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      valid = (c == 3);
      op = (c == 3) ? 3'b000 : 3'b101;
      if (vo) strobes++;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_ready", {63'd0, ready}, 64'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (vo) strobes++;
    end
    check_eq("flush_nostrobe", 64'(strobes), 64'd0);
    check_eq("flush_hold_result", {32'd0, res}, 64'd0);
    run_op(1'b0, 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, "mul_after_flush");

    // 8-bit instance: normal MUL, then reset in the middle of CALC.
    run_op(1'b1, 3'b000, 32'h0F, 32'h0F, 5'd3, 32'hE1, "mul8");
    strobes = 0;
    @(negedge clk);
    valid8 = 1'b1; op8 = 3'b000; a8 = 8'd9; b8 = 8'd9; rd8 = 5'd4;
    @(negedge clk);
    valid8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check_eq("rst8_ready", {63'd0, ready8}, 64'd1);
    check_eq("rst8_result", {56'd0, res8}, 64'd0);
    check_eq("rst8_rd", {59'd0, rdo8}, 64'd0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (vo8) strobes++;
    end
    check_eq("rst8_nostrobe", 64'(strobes), 64'd0);
    run_op(1'b1, 3'b000, 32'd3, 32'd5, 5'd2, 32'd15, "mul8_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative, parametrised multiply/divide unit for the EX stage. It executes the RISC-V M-extension operations selected by funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over a fixed-latency shift-add / restoring-divide datapath. It exposes a valid/ready request port so the pipeline control can stall IF/ID/EX while the unit is busy. A tagged result is returned to the EX/MEM buffer.

## Interface
Parameters:
- XLEN, 32, operand/result width; even, ≥ 4
- CW, derived $clog2(XLEN+1), iteration counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- flush_i  in  1  abort in-flight operation (branch flush)
- valid_i  in  1  request; accepted on an edge where valid_i & ready_o & !flush_i
- ready_o  out  1  unit idle, may accept
- busy_o  out  1  operation in flight; pipeline stall request
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data_i  in  XLEN  multiplicand / dividend
- rs2_data_i  in  XLEN  multiplier / divisor
- rd_i  in  5  destination tag, passed through
- valid_o  out  1  one-cycle result strobe
- result_o  out  XLEN  result
- rd_o  out  5  tag of result

## Operation
- States: IDLE, CALC, DONE. ready_o = (state==IDLE); busy_o = (state!=IDLE).
- IDLE: on accept, register op, rd, operand magnitudes and result-sign flags; counter := 0; go to CALC. valid_i while not ready_o is ignored.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both signed.
  - All others: unsigned.
  - Signed operands are converted to magnitude at accept.
- Result sign:
  - Product: negated if the operand signs differ.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the sign of the dividend.
- Multiply: radix-2 shift-add, one bit per cycle, 2·XLEN product. MUL returns the low half; MULH* return the high half. Sign correction is applied to the full 2·XLEN product.
- Divide: restoring, one quotient bit per cycle, XLEN+1-bit partial remainder.
- Special cases: precomputed at accept, selected at completion. Latency is unchanged.
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1): DIV → most-negative; REM → 0.
- CALC runs exactly XLEN iterations (counter 0..XLEN−1). On the last iteration edge, the final signed/selected result is written to result_o and rd_o, valid_o is set, and the state moves to DONE.
- DONE: valid_o high for this one cycle; return to IDLE next edge.
- result_o/rd_o hold their last completed value until the next completion or reset. flush does not clear them.
- flush_i in CALC or DONE: next state IDLE, valid_o := 0, no result produced. flush_i in IDLE blocks acceptance.

## Timing
- Reset values: state IDLE, valid_o 0, result_o 0, rd_o 0, counter 0; hence ready_o 1, busy_o 0 in the first post-reset cycle.
- Accept at the edge ending cycle 0. CALC occupies cycles 1..XLEN. valid_o is high in cycle XLEN+1 (33 for XLEN=32), independent of operands and op.
- Earliest next accept is at the end of cycle XLEN+2. Throughput is one op per XLEN+2 cycles.
- busy_o rises in cycle 1 and falls in the cycle after DONE. Same-cycle stalling of the issuing instruction is the pipeline control's job, using valid_i & ready_o.
- Simultaneous events:
  - rst_i beats flush_i, and flush_i beats valid_i.
  - flush_i during DONE suppresses valid_o on the following cycle only. valid_o is already registered, so the strobe in the flush cycle itself stands.
- Reset mid-CALC: next cycle IDLE, no valid_o, outputs at reset values.
- Operand inputs are don't-care after the accept edge.

## Test plan
- MUL 7 × 0xFFFFFFFD, rd 5 → valid_o only in cycle 33, result 0xFFFFFFEB, rd_o 5; ready_o low in cycles 1–33, high in 34.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 7/2 → 3. REMU 0xFFFFFFFF/16 → 15.
- DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0. All with latency 33.
- Flush in cycle 10 of a DIV → no valid_o, ready_o high next cycle. A following MUL 3×4 is accepted and returns 12. valid_i pulses while busy are ignored.
- XLEN=8 build: MUL 0x0F×0x0F → 0xE1; rst_i mid-CALC → no strobe, result_o 0; valid_o in cycle 9 for an op accepted after reset.
